// File: rtl/ascii_number_string_writer_pkg.sv
// Shared constants and FSM encoding for the ASCII number string writer.
package ascii_number_string_writer_pkg;

    localparam int NUM_DIGITS           = 10;
    localparam int BITS_PER_ASCII_DIGIT = 8;
    localparam int BIN_BITS             = 40;
    localparam int BCD_BITS             = 4 * NUM_DIGITS;
    // Two spare BCD digits keep the conversion of out-of-range values well-formed.
    localparam int BCD_INT_DIGITS       = NUM_DIGITS + 2;
    localparam int BCD_INT_BITS         = 4 * BCD_INT_DIGITS;
    localparam int STR_BITS             = NUM_DIGITS * BITS_PER_ASCII_DIGIT;
    localparam int CNT_BITS             = 6;

    localparam logic [BIN_BITS-1:0] SCROLL_THRESHOLD = 40'd9999;
    localparam logic [BIN_BITS-1:0] OVERFLOW_LIMIT   = 40'd9_999_999_999;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_BLANK = 8'h00;
    localparam logic [7:0] ASCII_E     = 8'h45;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        PUBLISH = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_nibble_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_nibble_adjust (
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);

    // Pre-shift correction so the following left shift carries into the next digit.
    always_comb o_nibble = (i_nibble >= 4'd5) ? i_nibble + 4'd3 : i_nibble;

endmodule

// File: rtl/ascii_number_string_writer.sv
// Binary-to-ASCII decimal string producer for the scrolling display.
// Sequential double-dabble, one input bit per clock.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros, never digit 0).
module ascii_number_string_writer
    import ascii_number_string_writer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [BIN_BITS-1:0] numberToConvert,
    input  logic                start,
    output logic                busy,
    output logic [STR_BITS-1:0] asciiString,
    output logic                needToScroll,
    output logic                latchNewString,
    output logic                overflow
);

    state_t                  r_state;
    logic [BIN_BITS-1:0]     r_bin;
    logic [BCD_INT_BITS-1:0] r_bcd;
    logic [CNT_BITS-1:0]     r_cnt;
    logic                    r_scroll_pend;
    logic                    r_ovf_pend;
    logic [BCD_INT_BITS-1:0] w_bcd_adj;
    logic [STR_BITS-1:0]     w_ascii;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    w_lead;
`endif

    for (genvar g = 0; g < BCD_INT_DIGITS; g++) begin : g_adj
        bcd_nibble_adjust u_adj (
            .i_nibble (r_bcd[4*g +: 4]),
            .o_nibble (w_bcd_adj[4*g +: 4])
        );
    end

    // Map the low BCD digits to ASCII, optionally blanking leading zeros.
    always_comb begin
        w_ascii = '0;
`ifdef LEADING_ZERO_BLANK_EN
        w_lead  = 1'b1;
`endif
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            w_ascii[d*BITS_PER_ASCII_DIGIT +: BITS_PER_ASCII_DIGIT] =
                ASCII_ZERO + {4'h0, r_bcd[d*4 +: 4]};
`ifdef LEADING_ZERO_BLANK_EN
            if (r_bcd[d*4 +: 4] != 4'h0)
                w_lead = 1'b0;
            if (w_lead && d != 0)
                w_ascii[d*BITS_PER_ASCII_DIGIT +: BITS_PER_ASCII_DIGIT] = ASCII_BLANK;
`endif
        end
    end

    // IDLE -> CONVERT (BIN_BITS cycles) -> PUBLISH -> IDLE, all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_bin          <= '0;
            r_bcd          <= '0;
            r_cnt          <= '0;
            r_scroll_pend  <= 1'b0;
            r_ovf_pend     <= 1'b0;
            busy           <= 1'b0;
            asciiString    <= '0;
            needToScroll   <= 1'b0;
            latchNewString <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            latchNewString <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin         <= numberToConvert;
                        r_bcd         <= '0;
                        r_cnt         <= '0;
                        r_scroll_pend <= numberToConvert > SCROLL_THRESHOLD;
                        r_ovf_pend    <= numberToConvert > OVERFLOW_LIMIT;
                        busy          <= 1'b1;
                        r_state       <= CONVERT;
                    end
                end
                CONVERT: begin
                    // The bit shifted out of the top spare digit is discarded;
                    // such values are already flagged as overflow.
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_cnt          <= r_cnt + 1'b1;
                    if (r_cnt == CNT_BITS'(BIN_BITS - 1))
                        r_state <= PUBLISH;
                end
                PUBLISH: begin
                    asciiString    <= r_ovf_pend ? {NUM_DIGITS{ASCII_E}} : w_ascii;
                    needToScroll   <= r_scroll_pend;
                    overflow       <= r_ovf_pend;
                    latchNewString <= 1'b1;
                    busy           <= 1'b0;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_number_string_writer.sv
// Directed bench for ascii_number_string_writer; honours LEADING_ZERO_BLANK_EN.
module tb_ascii_number_string_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [39:0] num;
    logic        start;
    logic        busy;
    logic [79:0] asciiString;
    logic        needToScroll;
    logic        latchNewString;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    logic [79:0] S1234, S9999, S10000, S0, S555, S777, S42, S_ALL9, S_E;

    ascii_number_string_writer dut (
        .clk             (clk),
        .reset           (reset),
        .numberToConvert (num),
        .start           (start),
        .busy            (busy),
        .asciiString     (asciiString),
        .needToScroll    (needToScroll),
        .latchNewString  (latchNewString),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One start pulse, then bounded wait for the latch pulse.
    task automatic convert(input logic [39:0] v, input string tag);
        int          lat;
        logic [79:0] prev;
        prev = asciiString;
        @(negedge clk);
        num   = v;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, " busy"}, 80'(busy), 80'd1);
        lat = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 20) chk({tag, " hold"}, asciiString, prev);
            if (latchNewString) lat = k;
        end
        chk({tag, " latency"}, 80'(lat), 80'd41);
        chk({tag, " busy_at_pulse"}, 80'(busy), 80'd0);
        @(posedge clk);
        #1 chk({tag, " pulse_width"}, 80'(latchNewString), 80'd0);
    endtask

    initial begin
        int          pulses;
        int          pos [1:3];
        logic [79:0] str [1:3];
        int          seen;

`ifdef LEADING_ZERO_BLANK_EN
        S1234  = {48'h0, "1234"};
        S9999  = {48'h0, "9999"};
        S10000 = {40'h0, "10000"};
        S0     = {72'h0, "0"};
        S555   = {56'h0, "555"};
        S777   = {56'h0, "777"};
        S42    = {64'h0, "42"};
`else
        S1234  = "0000001234";
        S9999  = "0000009999";
        S10000 = "0000010000";
        S0     = "0000000000";
        S555   = "0000000555";
        S777   = "0000000777";
        S42    = "0000000042";
`endif
        S_ALL9 = "9999999999";
        S_E    = "EEEEEEEEEE";

        reset = 1'b1;
        start = 1'b0;
        num   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ascii", asciiString, 80'h0);
        chk("rst busy", 80'(busy), 80'd0);
        chk("rst latch", 80'(latchNewString), 80'd0);
        chk("rst scroll", 80'(needToScroll), 80'd0);
        chk("rst ovf", 80'(overflow), 80'd0);
        @(negedge clk);
        reset = 1'b0;

        convert(40'd1234, "n1234");
        chk("n1234 str", asciiString, S1234);
        chk("n1234 scroll", 80'(needToScroll), 80'd0);
        chk("n1234 ovf", 80'(overflow), 80'd0);

        convert(40'd9999, "n9999");
        chk("n9999 str", asciiString, S9999);
        chk("n9999 scroll", 80'(needToScroll), 80'd0);

        convert(40'd10000, "n10000");
        chk("n10000 str", asciiString, S10000);
        chk("n10000 scroll", 80'(needToScroll), 80'd1);

        convert(40'd9_999_999_999, "nmax10");
        chk("nmax10 str", asciiString, S_ALL9);
        chk("nmax10 ovf", 80'(overflow), 80'd0);
        chk("nmax10 scroll", 80'(needToScroll), 80'd1);

        convert(40'd10_000_000_000, "novf");
        chk("novf str", asciiString, S_E);
        chk("novf ovf", 80'(overflow), 80'd1);
        chk("novf scroll", 80'(needToScroll), 80'd1);

        convert(40'd0, "nzero");
        chk("nzero str", asciiString, S0);
        chk("nzero ovf", 80'(overflow), 80'd0);
        chk("nzero scroll", 80'(needToScroll), 80'd0);

        // start held high; input changes mid-flight only affect the next conversion
        @(negedge clk);
        num    = 40'd555;
        start  = 1'b1;
        pulses = 0;
        pos    = '{0, 0, 0};
        str    = '{80'h0, 80'h0, 80'h0};
        @(posedge clk);
        for (int k = 1; k <= 125; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) num = 40'd777;
            if (latchNewString) begin
                pulses++;
                if (pulses <= 3) begin
                    pos[pulses] = k;
                    str[pulses] = asciiString;
                end
            end
        end
        start = 1'b0;
        chk("held pulses", 80'(pulses), 80'd3);
        chk("held pos1", 80'(pos[1]), 80'd41);
        chk("held pos2", 80'(pos[2]), 80'd83);
        chk("held pos3", 80'(pos[3]), 80'd125);
        chk("held str1", str[1], S555);
        chk("held str2", str[2], S777);
        @(posedge clk);
        #1 chk("held idle", 80'(busy), 80'd0);

        convert(40'hFF_FFFF_FFFF, "nfull");
        chk("nfull str", asciiString, S_E);
        chk("nfull ovf", 80'(overflow), 80'd1);

        // reset in the middle of a conversion
        @(negedge clk);
        num   = 40'd12345;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst ascii", asciiString, 80'h0);
        chk("mid_rst busy", 80'(busy), 80'd0);
        chk("mid_rst scroll", 80'(needToScroll), 80'd0);
        chk("mid_rst ovf", 80'(overflow), 80'd0);
        chk("mid_rst latch", 80'(latchNewString), 80'd0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (latchNewString) seen++;
        end
        chk("mid_rst no_pulse", 80'(seen), 80'd0);

        convert(40'd42, "n42");
        chk("n42 str", asciiString, S42);
        chk("n42 scroll", 80'(needToScroll), 80'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
